// File: rtl/bit_vote_stream.sv
// bit_vote_stream: per-frame popcount, at-least and exactly flags, and a
// windowed popcount accumulator, delivered over a valid/ready stream.
//
// Handshake: a frame moves on any rising edge where in_valid && in_ready,
// and a result is consumed on any rising edge where out_valid && out_ready.
// in_ready is combinational: it is high outside reset whenever the result
// register is empty or is being drained in the same cycle. There is no skid
// buffer, so the block sustains one frame per cycle. The FSM state is
// visible directly on out_valid (FULL <=> out_valid).
module bit_vote_stream #(
   parameter  int WIDTH  = 4,
   parameter  int THRESH = 3,
   parameter  int EXACT  = 2,
   parameter  int WINDOW = 4,
   localparam int CW     = $clog2(WIDTH + 1),
   localparam int SW     = $clog2(WIDTH * WINDOW + 1),
   localparam int IW     = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WIDTH-1:0] in_bits,
   input  logic          win_clear,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_pop,
   output logic          out_ge,
   output logic          out_eq,
   output logic [SW-1:0] out_win_sum,
   output logic          out_win_done
);

   localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW - 1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   pop_q, pop_d;
   logic            ge_q, ge_d;
   logic            eq_q, eq_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic            done_q, done_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [SW-1:0]   acc_q, acc_d;

   logic            accept;
   logic            consume;
   logic [CW-1:0]   frame_pop;
   logic [SW-1:0]   win_base;
   logic [SW-1:0]   win_sum;
   logic [IW-1:0]   eff_idx;
   logic            eff_last;

   // Handshake decode; reset blocks acceptance so no frame is taken in a reset cycle.
   always_comb begin
      in_ready = !rst && ((state_q == S_EMPTY) || out_ready);
      accept   = in_valid && in_ready;
      consume  = (state_q == S_FULL) && out_ready;
   end

   // Ones count of the incoming frame, accumulated at full CW width.
   always_comb begin
      frame_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         frame_pop = frame_pop + CW'(in_bits[i]);
      end
   end

   // Window arithmetic: win_clear or index 0 starts a fresh running total.
   always_comb begin
      win_base = (win_clear || (idx_q == '0)) ? '0 : acc_q;
      win_sum  = win_base + SW'(frame_pop);
      eff_idx  = win_clear ? '0 : idx_q;
      eff_last = (eff_idx == LAST_IDX);
   end

   // Next-state FSM: fill on accept, drain on consume without a refill.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_FULL;
         S_FULL:  if (consume && !accept) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   // Next-state datapath: results load on accept, window state also clears on win_clear.
   always_comb begin
      pop_d  = pop_q;
      ge_d   = ge_q;
      eq_d   = eq_q;
      sum_d  = sum_q;
      done_d = done_q;
      idx_d  = idx_q;
      acc_d  = acc_q;
      if (accept) begin
         pop_d  = frame_pop;
         ge_d   = (frame_pop >= CW'(THRESH));
         eq_d   = (frame_pop == CW'(EXACT));
         sum_d  = win_sum;
         done_d = eff_last;
         acc_d  = win_sum;
         idx_d  = eff_last ? '0 : (eff_idx + IW'(1));
      end else if (win_clear) begin
         idx_d = '0;
         acc_d = '0;
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         pop_q   <= '0;
         ge_q    <= 1'b0;
         eq_q    <= 1'b0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
         ge_q    <= ge_d;
         eq_q    <= eq_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   // Result registers drive the outputs directly.
   always_comb begin
      out_valid    = (state_q == S_FULL);
      out_pop      = pop_q;
      out_ge       = ge_q;
      out_eq       = eq_q;
      out_win_sum  = sum_q;
      out_win_done = done_q;
   end

endmodule

// File: tb/tb_bit_vote_stream.sv
// Bench for bit_vote_stream: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a stream-level model.
module tb_bit_vote_stream;

   localparam int WIDTH  = 4;
   localparam int THRESH = 3;
   localparam int EXACT  = 2;
   localparam int WINDOW = 4;
   localparam int CW     = $clog2(WIDTH + 1);
   localparam int SW     = $clog2(WIDTH * WINDOW + 1);

   typedef struct packed {
      logic [CW-1:0] pop;
      logic          ge;
      logic          eq;
      logic [SW-1:0] sum;
      logic          done;
   } res_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_bits;
   logic             win_clear;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_pop;
   logic             out_ge;
   logic             out_eq;
   logic [SW-1:0]    out_win_sum;
   logic             out_win_done;

   bit_vote_stream #(
      .WIDTH (WIDTH),
      .THRESH(THRESH),
      .EXACT (EXACT),
      .WINDOW(WINDOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_bits     (in_bits),
      .win_clear   (win_clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pop     (out_pop),
      .out_ge      (out_ge),
      .out_eq      (out_eq),
      .out_win_sum (out_win_sum),
      .out_win_done(out_win_done)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   res_t exp_q[$];   // results expected to be held by the block (0 or 1 entries)
   res_t got_q[$];   // results actually consumed, for literal checks
   int   m_idx  = 0;
   int   m_acc  = 0;
   bit   m_known = 1'b0;
   bit   m_zero  = 1'b0;
   logic m_rdy;
   res_t m_res;
   res_t dut_res;
   int   m_p;
   int   m_ei;

   // Compare the DUT with the model mid-cycle, then advance the model to the
   // state that the coming rising edge must produce.
   always @(negedge clk) begin
      m_rdy   = !rst && ((exp_q.size() == 0) || out_ready);
      dut_res = {out_pop, out_ge, out_eq, out_win_sum, out_win_done};
      check("in_ready", in_ready, m_rdy);
      if (m_known) begin
         check("out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0)
            check("result", dut_res, exp_q[0]);
         else if (m_zero)
            check("reset_zero", dut_res, '0);
      end
      if (!rst && out_valid && out_ready) got_q.push_back(dut_res);

      if (rst) begin
         exp_q.delete();
         m_idx   = 0;
         m_acc   = 0;
         m_known = 1'b1;
         m_zero  = 1'b1;
      end else begin
         if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
         if (in_valid && m_rdy) begin
            m_p  = $countones(in_bits);
            m_ei = win_clear ? 0 : m_idx;
            m_acc = ((m_ei == 0) ? 0 : m_acc) + m_p;
            m_res.pop  = CW'(m_p);
            m_res.ge   = (m_p >= THRESH);
            m_res.eq   = (m_p == EXACT);
            m_res.sum  = SW'(m_acc);
            m_res.done = (m_ei == WINDOW - 1);
            m_idx = (m_ei == WINDOW - 1) ? 0 : m_ei + 1;
            exp_q.push_back(m_res);
            m_zero = 1'b0;
         end else if (win_clear) begin
            m_idx = 0;
            m_acc = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] b, input logic wc, output int waited);
      bit took;
      took      = 1'b0;
      waited    = 0;
      in_valid  = 1'b1;
      in_bits   = b;
      win_clear = wc;
      while (!took && waited < 50) begin
         @(negedge clk);
         took = in_valid && in_ready && !rst;
         waited++;
         @(posedge clk);
         #1;
      end
      if (!took) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got no accept expected accept of %0h", b);
      end
      in_valid  = 1'b0;
      win_clear = 1'b0;
   endtask

   function automatic res_t mk(input int pop, input bit ge, input bit eq, input int sum, input bit done);
      res_t r;
      r.pop  = CW'(pop);
      r.ge   = ge;
      r.eq   = eq;
      r.sum  = SW'(sum);
      r.done = done;
      return r;
   endfunction

   task automatic chk_got(input string name, input int i, input res_t e);
      if (i >= got_q.size()) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got %0d results expected index %0d", name, got_q.size(), i);
      end else begin
         check(name, got_q[i], e);
      end
   endtask

   task automatic chk_flags(input string name, input int i, input int pop, input bit ge, input bit eq);
      if (i >= got_q.size()) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got %0d results expected index %0d", name, got_q.size(), i);
      end else begin
         check(name, {got_q[i].pop, got_q[i].ge, got_q[i].eq}, {CW'(pop), ge, eq});
      end
   endtask

   // ---------------- stimulus ----------------
   int w;
   int total;
   bit took_r;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_bits   = 4'b0101;
      win_clear = 1'b0;
      out_ready = 1'b1;

      // Reset held two cycles with in_valid asserted.
      repeat (2) begin
         @(negedge clk);
         check("rst_in_ready", in_ready, 1'b0);
         check("rst_outputs", {out_valid, out_pop, out_ge, out_eq, out_win_sum, out_win_done}, '0);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      cycles(1);

      // Exhaustive frame sweep, back to back.
      got_q.delete();
      total = 0;
      for (int i = 0; i < 16; i++) begin
         send(WIDTH'(i), 1'b0, w);
         total += w;
      end
      cycles(2);
      check("sweep_throughput", total, 16);
      chk_flags("sweep_0000", 0, 0, 1'b0, 1'b0);
      chk_flags("sweep_0011", 3, 2, 1'b0, 1'b1);
      chk_flags("sweep_0111", 7, 3, 1'b1, 1'b0);
      chk_flags("sweep_1111", 15, 4, 1'b1, 1'b0);

      // Window accumulation.
      got_q.delete();
      send(4'b1111, 1'b0, w);
      send(4'b0011, 1'b0, w);
      send(4'b0000, 1'b0, w);
      send(4'b0111, 1'b0, w);
      send(4'b0001, 1'b0, w);
      cycles(2);
      chk_got("win_f0", 0, mk(4, 1, 0, 4, 0));
      chk_got("win_f1", 1, mk(2, 0, 1, 6, 0));
      chk_got("win_f2", 2, mk(0, 0, 0, 6, 0));
      chk_got("win_f3", 3, mk(3, 1, 0, 9, 1));
      chk_got("win_f4", 4, mk(1, 0, 0, 1, 0));

      // Backpressure.
      send(4'b1010, 1'b0, w);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bits   = 4'b1110;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_pop_eq", {out_valid, out_pop, out_eq}, {1'b1, CW'(2), 1'b1});
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(4'b1110, 1'b0, w);
      check("release_same_cycle", w, 1);
      @(negedge clk);
      check("release_result", {out_valid, out_pop, out_ge}, {1'b1, CW'(3), 1'b1});
      cycles(2);

      // win_clear together with an accept.
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      got_q.delete();
      send(4'b1111, 1'b0, w);
      send(4'b0111, 1'b0, w);
      send(4'b0011, 1'b1, w);
      send(4'b1100, 1'b0, w);
      send(4'b0001, 1'b0, w);
      send(4'b0001, 1'b0, w);
      cycles(2);
      chk_got("clr_f0", 0, mk(4, 1, 0, 4, 0));
      chk_got("clr_f1", 1, mk(3, 1, 0, 7, 0));
      chk_got("clr_0011", 2, mk(2, 0, 1, 2, 0));
      chk_got("clr_1100", 3, mk(2, 0, 1, 4, 0));
      chk_got("clr_f4", 4, mk(1, 0, 0, 5, 0));
      chk_got("clr_done", 5, mk(1, 0, 0, 6, 1));

      // Mid-operation reset with a pending result.
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      send(4'b1111, 1'b0, w);
      send(4'b0011, 1'b0, w);
      out_ready = 1'b0;
      @(negedge clk);
      check("pending_sum", {out_valid, out_win_sum}, {1'b1, SW'(6)});
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      out_ready = 1'b1;
      got_q.delete();
      send(4'b0001, 1'b0, w);
      cycles(2);
      chk_got("midrst_next", 0, mk(1, 0, 0, 1, 0));

      // Randomized traffic; the source holds a frame until it is taken.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         took_r = in_valid && in_ready && !rst;
         @(posedge clk);
         #1;
         if (!in_valid || took_r) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bits  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         win_clear = ($urandom_range(0, 7) == 0);
         rst       = ($urandom_range(0, 99) == 0);
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      win_clear = 1'b0;
      out_ready = 1'b1;
      cycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net against a stuck run.
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
